// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the result/status outputs and the external ALU hookup.
// The slave modport is the arbiter side; master is the requesters plus the external ALU.
interface alu_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] opa0;
    logic [7:0] opb0;
    logic [7:0] opa1;
    logic [7:0] opb1;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic       ack0;
    logic       ack1;
    logic       done0;
    logic       done1;
    logic [7:0] res;
    logic       busy;
    logic [7:0] op_cnt;
    logic [7:0] alu_opa;
    logic [7:0] alu_opb;
    logic [2:0] alu_sel;
    logic [7:0] alu_res;

    modport slave (
        input  req0, req1, opa0, opb0, opa1, opb1, sel0, sel1, alu_res,
        output ack0, ack1, done0, done1, res, busy, op_cnt, alu_opa, alu_opb, alu_sel
    );

    modport master (
        output req0, req1, opa0, opb0, opa1, opb1, sel0, sel1, alu_res,
        input  ack0, ack1, done0, done1, res, busy, op_cnt, alu_opa, alu_opb, alu_sel
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external 8-bit ALU: arbitrates, latches operands,
// runs one IDLE -> EXEC -> DONE pass per operation and returns a registered result.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         nrst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       accept_s;
    logic       grant_s;
    logic       win_q, win_d;
    logic       ptr_q, ptr_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] res_q, res_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;

    // Arbitration: a lone requester always wins; contention goes to the pointer or to requester 0
    always_comb begin
        accept_s = bus.req0 | bus.req1;
        grant_s  = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_s = RR_EN ? ptr_q : 1'b0;
        end else if (bus.req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic; ack and done are computed one state early so they leave a flop
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        sel_d   = sel_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    opa_d  = grant_s ? bus.opa1 : bus.opa0;
                    opb_d  = grant_s ? bus.opb1 : bus.opb0;
                    sel_d  = grant_s ? bus.sel1 : bus.sel0;
                    win_d  = grant_s;
                    // Priority passes to whichever requester did not just win
                    ptr_d  = ~grant_s;
                    ack0_d = ~grant_s;
                    ack1_d = grant_s;
                end else begin
                    ack0_d = 1'b0;
                    ack1_d = 1'b0;
                end
            end
            EXEC: begin
                res_d   = bus.alu_res;
                cnt_d   = cnt_q + 8'd1;
                done0_d = ~win_q;
                done1_d = win_q;
            end
            DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
            end
            default: begin
                ack0_d = 1'b0;
                ack1_d = 1'b0;
            end
        endcase
    end

    // Operand latches, result, counter and registered handshake outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            opa_q   <= 8'h00;
            opb_q   <= 8'h00;
            sel_q   <= 3'b000;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            res_q   <= 8'h00;
            cnt_q   <= 8'h00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    // ALU inputs come straight from the latches so they only move on an acceptance
    assign bus.alu_opa = opa_q;
    assign bus.alu_opb = opb_q;
    assign bus.alu_sel = sel_q;
    assign bus.res     = res_q;
    assign bus.op_cnt  = cnt_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance, each fed by a bench-side ALU,
// checked against a transaction-level model of grant order, result and operation count.
module tb_alu_arbiter;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic       m_ptr = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    alu_arbiter_if rr_if ();
    alu_arbiter_if fp_if ();

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .nrst(nrst), .bus(rr_if));
    alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .nrst(nrst), .bus(fp_if));

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return a - b;
            3'd5:    return a;
            3'd6:    return a & b;
            default: return b;
        endcase
    endfunction

    assign rr_if.alu_res = alu_f(rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel);
    assign fp_if.alu_res = alu_f(fp_if.alu_opa, fp_if.alu_opb, fp_if.alu_sel);

    // No cycle may carry more than one of ack0/ack1/done0/done1
    always @(negedge clk) begin
        if (nrst) begin
            checks++;
            if (int'(rr_if.ack0) + int'(rr_if.ack1) + int'(rr_if.done0) + int'(rr_if.done1) > 1) begin
                errors++;
                $display("FAIL overlap_rr: ack0=%b ack1=%b done0=%b done1=%b, at most one required",
                         rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.done1);
            end
            checks++;
            if (int'(fp_if.ack0) + int'(fp_if.ack1) + int'(fp_if.done0) + int'(fp_if.done1) > 1) begin
                errors++;
                $display("FAIL overlap_fp: ack0=%b ack1=%b done0=%b done1=%b, at most one required",
                         fp_if.ack0, fp_if.ack1, fp_if.done0, fp_if.done1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rr_if.req0 = 1'b0; rr_if.req1 = 1'b0;
        rr_if.opa0 = 8'h00; rr_if.opb0 = 8'h00; rr_if.sel0 = 3'd0;
        rr_if.opa1 = 8'h00; rr_if.opb1 = 8'h00; rr_if.sel1 = 3'd0;
        fp_if.req0 = 1'b0; fp_if.req1 = 1'b0;
        fp_if.opa0 = 8'h00; fp_if.opb0 = 8'h00; fp_if.sel0 = 3'd0;
        fp_if.opa1 = 8'h00; fp_if.opb1 = 8'h00; fp_if.sel1 = 3'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #2 nrst = 1'b0;
        @(posedge clk);
        #3 nrst = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'h00;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.done1, rr_if.busy, rr_if.res, rr_if.op_cnt,
             rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel} !== 40'h0) begin
            errors++;
            $display("FAIL reset_rr: res=%h op_cnt=%h busy=%b alu_opa=%h, all zero required",
                     rr_if.res, rr_if.op_cnt, rr_if.busy, rr_if.alu_opa);
        end
        checks++;
        if ({fp_if.ack0, fp_if.ack1, fp_if.done0, fp_if.done1, fp_if.busy, fp_if.res, fp_if.op_cnt,
             fp_if.alu_opa, fp_if.alu_opb, fp_if.alu_sel} !== 40'h0) begin
            errors++;
            $display("FAIL reset_fp: res=%h op_cnt=%h busy=%b alu_opa=%h, all zero required",
                     fp_if.res, fp_if.op_cnt, fp_if.busy, fp_if.alu_opa);
        end
        @(posedge clk);
        #3 nrst = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'h00;
        cyc();
    endtask

    task automatic test_single();
        rr_if.req0 = 1'b1; rr_if.opa0 = 8'h05; rr_if.opb0 = 8'h03; rr_if.sel0 = 3'b000;
        cyc();
        m_ptr = 1'b1;
        checks++;
        if ({rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.busy} !== 4'b1001) begin
            errors++;
            $display("FAIL single_ack: {ack0,ack1,done0,busy}=%b, 1001 required",
                     {rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.busy});
        end
        checks++;
        if ({rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel} !== {8'h05, 8'h03, 3'b000}) begin
            errors++;
            $display("FAIL single_alu_in: opa=%h opb=%h sel=%b, 05 03 000 required",
                     rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel);
        end
        rr_if.req0 = 1'b0; rr_if.opa0 = 8'hAA;
        cyc();
        m_cnt = m_cnt + 8'd1;
        checks++;
        if ({rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.done1} !== 4'b0010 || rr_if.res !== 8'h08) begin
            errors++;
            $display("FAIL single_done: {ack0,ack1,done0,done1}=%b res=%h, 0010 and 08 required",
                     {rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.done1}, rr_if.res);
        end
        checks++;
        if (rr_if.op_cnt !== m_cnt) begin
            errors++;
            $display("FAIL single_cnt: op_cnt=%h, %h required", rr_if.op_cnt, m_cnt);
        end
        cyc();
        checks++;
        if (rr_if.busy !== 1'b0 || rr_if.done0 !== 1'b0 || rr_if.res !== 8'h08
            || rr_if.alu_opa !== 8'h05) begin
            errors++;
            $display("FAIL single_idle: busy=%b done0=%b res=%h alu_opa=%h, 0 0 08 05 required",
                     rr_if.busy, rr_if.done0, rr_if.res, rr_if.alu_opa);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        rr_if.req0 = 1'b1; rr_if.opa0 = 8'h03; rr_if.opb0 = 8'h05; rr_if.sel0 = 3'b001;
        rr_if.req1 = 1'b1; rr_if.opa1 = 8'hF0; rr_if.opb1 = 8'h3C; rr_if.sel1 = 3'b110;
        cyc();
        checks++;
        if ({rr_if.ack0, rr_if.ack1} !== 2'b10) begin
            errors++;
            $display("FAIL rr_first_ack: {ack0,ack1}=%b, 10 required", {rr_if.ack0, rr_if.ack1});
        end
        rr_if.req0 = 1'b0;
        cyc();
        checks++;
        if ({rr_if.done0, rr_if.done1} !== 2'b10 || rr_if.res !== 8'hFE) begin
            errors++;
            $display("FAIL rr_first_done: {done0,done1}=%b res=%h, 10 and FE required",
                     {rr_if.done0, rr_if.done1}, rr_if.res);
        end
        cyc();
        checks++;
        if (rr_if.ack1 !== 1'b0 || rr_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_ignored_busy: ack1=%b busy=%b, 0 0 required", rr_if.ack1, rr_if.busy);
        end
        cyc();
        checks++;
        if ({rr_if.ack0, rr_if.ack1} !== 2'b01) begin
            errors++;
            $display("FAIL rr_second_ack: {ack0,ack1}=%b, 01 required", {rr_if.ack0, rr_if.ack1});
        end
        rr_if.req1 = 1'b0;
        cyc();
        checks++;
        if ({rr_if.done0, rr_if.done1} !== 2'b01 || rr_if.res !== 8'h30 || rr_if.op_cnt !== 8'd2) begin
            errors++;
            $display("FAIL rr_second_done: {done0,done1}=%b res=%h op_cnt=%h, 01 30 02 required",
                     {rr_if.done0, rr_if.done1}, rr_if.res, rr_if.op_cnt);
        end
        m_ptr = 1'b0;
        m_cnt = 8'd2;
        cyc();
    endtask

    task automatic test_fixed_priority();
        int grants = 0;
        int ack1_seen = 0;
        fp_if.req0 = 1'b1; fp_if.opa0 = 8'($urandom); fp_if.opb0 = 8'($urandom); fp_if.sel0 = 3'd2;
        fp_if.req1 = 1'b1; fp_if.opa1 = 8'($urandom); fp_if.opb1 = 8'($urandom); fp_if.sel1 = 3'd3;
        for (int i = 0; i < 30 && grants < 4; i++) begin
            cyc();
            if (fp_if.ack0 === 1'b1) grants++;
            if (fp_if.ack1 === 1'b1) ack1_seen++;
        end
        checks++;
        if (grants !== 4) begin
            errors++;
            $display("FAIL fp_grants: ack0 count=%0d within 30 cycles, 4 required", grants);
        end
        checks++;
        if (ack1_seen !== 0) begin
            errors++;
            $display("FAIL fp_ack1: ack1 pulses=%0d, 0 required", ack1_seen);
        end
        fp_if.req0 = 1'b0; fp_if.req1 = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_operand_change();
        rr_if.req1 = 1'b1; rr_if.opa1 = 8'h85; rr_if.opb1 = 8'h03; rr_if.sel1 = 3'b100;
        cyc();
        m_ptr = 1'b0;
        checks++;
        if ({rr_if.ack0, rr_if.ack1} !== 2'b01) begin
            errors++;
            $display("FAIL opchg_ack: {ack0,ack1}=%b, 01 required", {rr_if.ack0, rr_if.ack1});
        end
        rr_if.opa1 = 8'h00; rr_if.req1 = 1'b0;
        cyc();
        m_cnt = m_cnt + 8'd1;
        checks++;
        if (rr_if.done1 !== 1'b1 || rr_if.res !== 8'h82 || rr_if.op_cnt !== m_cnt) begin
            errors++;
            $display("FAIL opchg_res: done1=%b res=%h op_cnt=%h, 1 82 %h required",
                     rr_if.done1, rr_if.res, rr_if.op_cnt, m_cnt);
        end
        cyc();
    endtask

    task automatic test_reset_in_exec();
        int stray = 0;
        rr_if.req0 = 1'b1; rr_if.opa0 = 8'h11; rr_if.opb0 = 8'h22; rr_if.sel0 = 3'd3;
        cyc();
        checks++;
        if (rr_if.ack0 !== 1'b1 || rr_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_ack: ack0=%b busy=%b, 1 1 required", rr_if.ack0, rr_if.busy);
        end
        rr_if.req0 = 1'b0;
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({rr_if.ack0, rr_if.ack1, rr_if.done0, rr_if.done1, rr_if.busy, rr_if.res, rr_if.op_cnt,
             rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel} !== 40'h0) begin
            errors++;
            $display("FAIL rst_exec_clear: ack0=%b busy=%b res=%h op_cnt=%h alu_opa=%h, all zero required",
                     rr_if.ack0, rr_if.busy, rr_if.res, rr_if.op_cnt, rr_if.alu_opa);
        end
        @(posedge clk);
        #3 nrst = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rr_if.done0 !== 1'b0 || rr_if.done1 !== 1'b0 || rr_if.ack0 !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0 || rr_if.op_cnt !== 8'h00) begin
            errors++;
            $display("FAIL rst_exec_after: stray pulses=%0d op_cnt=%h, 0 and 00 required", stray, rr_if.op_cnt);
        end
    endtask

    task automatic test_random_wrap();
        logic [1:0] r;
        logic       w;
        logic [7:0] ea, eb, eres;
        logic [2:0] es;
        for (int n = 0; n < 256; n++) begin
            r = 2'($urandom_range(1, 3));
            rr_if.req0 = r[0]; rr_if.req1 = r[1];
            rr_if.opa0 = 8'($urandom); rr_if.opb0 = 8'($urandom); rr_if.sel0 = 3'($urandom);
            rr_if.opa1 = 8'($urandom); rr_if.opb1 = 8'($urandom); rr_if.sel1 = 3'($urandom);
            w = (r == 2'b11) ? m_ptr : r[1];
            ea = w ? rr_if.opa1 : rr_if.opa0;
            eb = w ? rr_if.opb1 : rr_if.opb0;
            es = w ? rr_if.sel1 : rr_if.sel0;
            eres = alu_f(ea, eb, es);
            m_ptr = ~w;
            cyc();
            checks++;
            if ({rr_if.ack0, rr_if.ack1} !== (w ? 2'b01 : 2'b10) || rr_if.busy !== 1'b1
                || {rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel} !== {ea, eb, es}) begin
                errors++;
                $display("FAIL rand_ack[%0d]: {ack0,ack1}=%b busy=%b alu=%h/%h/%0d, winner %0d alu=%h/%h/%0d required",
                         n, {rr_if.ack0, rr_if.ack1}, rr_if.busy, rr_if.alu_opa, rr_if.alu_opb, rr_if.alu_sel,
                         w, ea, eb, es);
            end
            rr_if.req0 = 1'b0; rr_if.req1 = 1'b0;
            rr_if.opa0 = 8'($urandom); rr_if.opa1 = 8'($urandom); rr_if.sel0 = 3'($urandom);
            cyc();
            m_cnt = m_cnt + 8'd1;
            checks++;
            if ({rr_if.done0, rr_if.done1} !== (w ? 2'b01 : 2'b10) || rr_if.res !== eres
                || rr_if.op_cnt !== m_cnt || rr_if.alu_opa !== ea) begin
                errors++;
                $display("FAIL rand_done[%0d]: {done0,done1}=%b res=%h op_cnt=%h alu_opa=%h, winner %0d res=%h op_cnt=%h alu_opa=%h required",
                         n, {rr_if.done0, rr_if.done1}, rr_if.res, rr_if.op_cnt, rr_if.alu_opa,
                         w, eres, m_cnt, ea);
            end
            cyc();
            checks++;
            if (rr_if.busy !== 1'b0 || rr_if.res !== eres) begin
                errors++;
                $display("FAIL rand_idle[%0d]: busy=%b res=%h, 0 and %h required", n, rr_if.busy, rr_if.res, eres);
            end
        end
        checks++;
        if (rr_if.op_cnt !== 8'h00) begin
            errors++;
            $display("FAIL wrap: op_cnt=%h after 256 operations, 00 required", rr_if.op_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_operand_change();
        test_reset_in_exec();
        test_random_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1.
REQ-005 opa0, opb0 / opa1, opb1  input  8 each  operands of requester 0 / 1.
REQ-006 sel0 / sel1  input  3 each  ALU operation code of requester 0 / 1; all 8 codes legal.
REQ-007 ack0 / ack1  output  1 each  one-cycle pulse; the request was accepted and operands were consumed.
REQ-008 done0 / done1  output  1 each  one-cycle pulse; res is valid for that requester.
REQ-009 res  output  8  registered result; holds its value until the next done.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 op_cnt  output  8  count of completed operations.
REQ-012 alu_opa, alu_opb  output  8 each  operands driven to the external 8-bit ALU.
REQ-013 alu_sel  output  3  operation code driven to the external ALU.
REQ-014 alu_res  input  8  combinational result returned by the external ALU.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-016 IDLE: if req0 or req1 is sampled high at the edge, the block SHALL select a winner, latch that requester's opa/opb/sel into internal registers, record the winner ID and go to EXEC; otherwise it stays in IDLE.
REQ-017 Arbitration with RR_EN=1: on simultaneous requests the winner SHALL be the requester named by a priority pointer; the pointer moves to the other requester after each acceptance; a single requester always wins regardless of the pointer.
REQ-018 Arbitration with RR_EN=0: requester 0 SHALL win every simultaneous request.
REQ-019 EXEC: alu_opa/alu_opb/alu_sel SHALL equal the latched registers; ack of the winner SHALL be high for this cycle only; at the next edge the block SHALL load alu_res into res and go to DONE.
REQ-020 DONE: done of the winner SHALL be high for this cycle only; op_cnt SHALL increment by 1 and wrap 0xFF->0x00; the next state SHALL be IDLE.
REQ-021 In IDLE and DONE, alu_opa/alu_opb/alu_sel SHALL hold the last latched values, so no ALU input toggles outside EXEC.
REQ-022 Latency SHALL be: request sampled at edge N, ack high in cycle N+1, done high and res valid in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-023 Requests arriving while busy SHALL be ignored until IDLE; a requester SHALL hold req until it sees ack and deassert it the cycle after ack, otherwise it is served again.
REQ-024 Operand changes or req deassertion after the acceptance edge SHALL NOT affect the operation in flight.
REQ-025 At most one ack and at most one done SHALL be high in any cycle; ack and done SHALL never be high in the same cycle.
REQ-026 The block SHALL NOT interpret operands; res SHALL equal alu_res bit-for-bit.

Reset
REQ-027 While nrst=0, without waiting for a clock edge: state=IDLE, res=0x00, op_cnt=0x00, ack0/ack1/done0/done1/busy=0, alu_opa=alu_opb=0x00, alu_sel=3'b000, priority pointer=requester 0.
REQ-028 Reset asserted in EXEC or DONE SHALL discard the in-flight operation: no ack or done pulse follows and op_cnt is unchanged.
REQ-029 After nrst deasserts, the first edge SHALL behave as in IDLE.

Verification
REQ-030 req0 with opa0=0x05, opb0=0x03, sel0=000 -> ack0 at N+1; done0 at N+2 with res=0x08; op_cnt=1.
REQ-031 req0 and req1 both high, RR_EN=1: req0 (sel0=001, opa0=0x03, opb0=0x05) and req1 (sel1=110, opa1=0xF0, opb1=0x3C) -> requester 0 done with res=0xFE first, then requester 1 done with res=0x30; no overlapping pulses.
REQ-032 RR_EN=0, both requesters held high for 4 grants -> every ack is ack0; ack1 never asserts.
REQ-033 req1 with sel1=100, opa1=0x85, opb1=0x03; opa1 changed to 0x00 in the ack cycle -> res=0x82.
REQ-034 nrst pulsed low during EXEC -> outputs go to reset values immediately; no done pulse; op_cnt=0.
REQ-035 256 single operations -> op_cnt wraps to 0x00; busy low only between operations.
